// File: rtl/snn_layer1_pkg.sv
// Shared types, default widths and the saturating add used by the layer-1 membrane update generator.
package snn_layer1_pkg;

    localparam int unsigned BIT_WIDTH_MEMBRANE_DEF = 17;
    localparam int unsigned BIT_WIDTH_WEIGHT_DEF   = 8;
    localparam int unsigned NEURON_NUM_IN_SET_DEF  = 20;
    localparam int unsigned BIT_WIDTH_PRE_IDX_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_EMIT
    } fsm_state_e;

    // Operands arrive sign-extended to 32 bits, so the sum cannot wrap for m <= 30;
    // the result is clamped to the signed m-bit range.
    function automatic logic signed [31:0] sat_add_membrane(input logic signed [31:0] a,
                                                            input logic signed [31:0] b,
                                                            input int                 m);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (m - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (m - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage

// File: rtl/membrane_accum_lane.sv
// One neuron lane: accumulator register with a saturating signed weight add.
module membrane_accum_lane
    import snn_layer1_pkg::*;
#(
    parameter int unsigned BIT_WIDTH_MEMBRANE = BIT_WIDTH_MEMBRANE_DEF,
    parameter int unsigned BIT_WIDTH_WEIGHT   = BIT_WIDTH_WEIGHT_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic [BIT_WIDTH_WEIGHT-1:0]   weight,
    output logic [BIT_WIDTH_MEMBRANE-1:0] acc
);

    logic [BIT_WIDTH_MEMBRANE-1:0] acc_q, acc_d;
    logic signed [31:0]            sum_sat;

    always_comb begin
        sum_sat = sat_add_membrane(32'(signed'(acc_q)), 32'(signed'(weight)),
                                   int'(BIT_WIDTH_MEMBRANE));
        acc_d   = acc_q;
        if (clr)     acc_d = '0;
        else if (en) acc_d = BIT_WIDTH_MEMBRANE'(sum_sat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/membrane_update_gen_layer1.sv
// Per-timestep synaptic accumulator: spike indices fetch weight rows that are summed per lane,
// and the totals are presented with a one-cycle valid at end of timestep.
module membrane_update_gen_layer1
    import snn_layer1_pkg::*;
#(
    parameter int unsigned BIT_WIDTH_MEMBRANE = BIT_WIDTH_MEMBRANE_DEF,
    parameter int unsigned BIT_WIDTH_WEIGHT   = BIT_WIDTH_WEIGHT_DEF,
    parameter int unsigned NEURON_NUM_IN_SET  = NEURON_NUM_IN_SET_DEF,
    parameter int unsigned BIT_WIDTH_PRE_IDX  = BIT_WIDTH_PRE_IDX_DEF
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            timestep_start_i,
    input  logic                                            pre_spike_valid_i,
    input  logic [BIT_WIDTH_PRE_IDX-1:0]                    pre_spike_idx_i,
    output logic                                            pre_spike_ready_o,
    input  logic                                            timestep_end_i,
    output logic                                            weight_rd_en_o,
    output logic [BIT_WIDTH_PRE_IDX-1:0]                    weight_addr_o,
    input  logic [BIT_WIDTH_WEIGHT*NEURON_NUM_IN_SET-1:0]   weight_data_i,
    output logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0] membrane_update_o,
    output logic                                            membrane_update_valid_o,
    output logic                                            busy_o
);

    fsm_state_e state_q;
    logic       rd_pending_q;
    logic       hs;
    logic       clr;

    assign pre_spike_ready_o       = (state_q == ST_ACCUM);
    assign hs                      = pre_spike_valid_i & pre_spike_ready_o;
    assign weight_rd_en_o          = hs;
    assign weight_addr_o           = hs ? pre_spike_idx_i : '0;
    assign clr                     = (state_q == ST_IDLE) & timestep_start_i;
    assign membrane_update_valid_o = (state_q == ST_EMIT);
    assign busy_o                  = (state_q != ST_IDLE);

    // rd_pending tracks the one-cycle SRAM latency; DRAIN exists so the last row lands before EMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= hs;
            case (state_q)
                ST_IDLE:  if (timestep_start_i) state_q <= ST_ACCUM;
                ST_ACCUM: if (timestep_end_i)   state_q <= ST_DRAIN;
                ST_DRAIN: state_q <= ST_EMIT;
                ST_EMIT:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NEURON_NUM_IN_SET; i++) begin : gen_lane
        membrane_accum_lane #(
            .BIT_WIDTH_MEMBRANE(BIT_WIDTH_MEMBRANE),
            .BIT_WIDTH_WEIGHT  (BIT_WIDTH_WEIGHT)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (clr),
            .en     (rd_pending_q),
            .weight (weight_data_i[BIT_WIDTH_WEIGHT*i +: BIT_WIDTH_WEIGHT]),
            .acc    (membrane_update_o[BIT_WIDTH_MEMBRANE*i +: BIT_WIDTH_MEMBRANE])
        );
    end

endmodule
